// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce filter.
// Holds the FSM state encoding and the default qualification length.
package debounce_pkg;

  // Number of extra consecutive agreeing samples needed to accept a new level.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // The two stable states hold a clean level. The two check states are
  // qualifying a candidate change. All four 2-bit encodings are used.
  typedef enum logic [1:0] {
    ST_LOW      = 2'b00,
    ST_CHK_HIGH = 2'b01,
    ST_HIGH     = 2'b10,
    ST_CHK_LOW  = 2'b11
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Both flops reset to 0, so a reset always presents a low level downstream.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // Shift the raw level through two flops; the first may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter for a bouncing switch or pin.
// A new level is accepted only after DEBOUNCE_CYCLES+1 consecutive samples
// agree. Any shorter pulse or glitch is rejected, and the count starts again.
// Optional macro DEBOUNCE_SYNC_EN puts a two-flop synchronizer (sync2) in front
// of the FSM. That lets 'in' be asynchronous, at the cost of 2 cycles of latency.
// The current FSM state is visible on dbg_state so checkers can observe it.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in,
  output logic   out,
  output logic   busy,
  output state_t dbg_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

`ifdef DEBOUNCE_SYNC_EN
  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (w_s)
  );
`else
  assign w_s = in;
`endif

  // State and qualification counter register; reset discards any qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. The counter only runs while a check state keeps seeing
  // the candidate level. Every other path clears it, so an abort never carries
  // a count over into the next qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_LOW: begin
        if (w_s) w_state_nxt = ST_CHK_HIGH;
      end
      ST_CHK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!w_s) w_state_nxt = ST_CHK_LOW;
      end
      ST_CHK_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
      end
    endcase
  end

  // Moore outputs decoded from the registered state only.
  // There is no combinational path from 'in' to these outputs.
  assign out       = (r_state == ST_HIGH) || (r_state == ST_CHK_LOW);
  assign busy      = (r_state == ST_CHK_HIGH) || (r_state == ST_CHK_LOW);
  assign dbg_state = r_state;

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of extra consecutive agreeing samples needed to accept a level change; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in, input, 1 bit: raw, bouncing level from a switch or pin.
REQ-005 The block SHALL have port out, output, 1 bit: debounced clean level, directly usable by the downstream edge-detector stage.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-007 The block SHALL implement a Moore FSM with states ST_LOW, ST_CHK_HIGH, ST_HIGH and ST_CHK_LOW, plus a counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
REQ-008 In ST_LOW, a sampled s=1 SHALL move the FSM to ST_CHK_HIGH with cnt=0; s=0 SHALL keep ST_LOW.
REQ-009 In ST_CHK_HIGH, s=0 SHALL return the FSM to ST_LOW (abort, cnt=0).
REQ-010 In ST_CHK_HIGH, s=1 with cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to ST_HIGH.
REQ-011 In ST_CHK_HIGH, s=1 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-012 ST_HIGH and ST_CHK_LOW SHALL behave symmetrically, with levels inverted.
REQ-013 s SHALL be the sampled input: the synchronizer output when DEBOUNCE_SYNC_EN is defined, otherwise in directly.
REQ-014 out SHALL be 1 exactly in ST_HIGH and ST_CHK_LOW; busy SHALL be 1 exactly in ST_CHK_HIGH and ST_CHK_LOW; both SHALL be registered-state decodes with no combinational path from in.
REQ-015 out SHALL change only after DEBOUNCE_CYCLES+1 consecutive edges sample the new level on s; the clk edge that completes the qualification SHALL update out.
REQ-016 Any pulse or glitch on s of DEBOUNCE_CYCLES or fewer samples SHALL NOT change out.
REQ-017 An aborted qualification SHALL restart from cnt=0 on the next opposite sample, with no carried-over count.
REQ-018 cnt SHALL never wrap; it SHALL hold at 0 in the stable states.
REQ-019 Unreachable state encodings SHALL recover to ST_LOW on the next edge.

Reset
REQ-020 While rst=1, the block SHALL asynchronously force state=ST_LOW, cnt=0, out=0, busy=0, and synchronizer flops=0.
REQ-021 Reset asserted mid-qualification SHALL discard the qualification.
REQ-022 After rst deasserts, the first edge SHALL evaluate per REQ-008.

Configuration
REQ-023 With macro DEBOUNCE_SYNC_EN defined, in SHALL pass through a two-flop synchronizer before the FSM, adding exactly 2 cycles of latency to out; in may then be asynchronous.
REQ-024 Without DEBOUNCE_SYNC_EN, the FSM SHALL sample in directly; in must then be synchronous to clk and latency follows REQ-015 exactly.

Structure
REQ-025 Package debounce_pkg SHALL hold the state enum type (2-bit, explicit encodings) and the DEBOUNCE_CYCLES_DEFAULT constant.
REQ-026 The synchronizer SHALL be sub-module sync2 (clk, rst, d, q; reset value 0), instantiated only under DEBOUNCE_SYNC_EN.

Verification (DEBOUNCE_CYCLES=4, macro undefined unless stated)
REQ-027 The bench SHALL cover reset: rst pulsed mid-ST_CHK_HIGH -> out=0, busy=0 immediately; after release, in=0 -> out stays 0.
REQ-028 The bench SHALL cover a clean rise: in 0->1 held -> busy=1 after edge 1, out=1 after edge 5, busy=0 after edge 5.
REQ-029 The bench SHALL cover glitch rejection: in=1 for 4 edges then 0 -> out stays 0 and busy returns to 0.
REQ-030 The bench SHALL cover bounce: in pattern 1,0,1,1,0,1,1,1,1,1 -> out rises only after the final 5-sample run.
REQ-031 The bench SHALL cover a clean fall from ST_HIGH: in=0 held -> out=0 after 5 edges; a 3-sample low glitch keeps out=1.
REQ-032 With DEBOUNCE_SYNC_EN defined, the bench SHALL check that the clean rise of REQ-028 gives out=1 after edge 7.
